// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state encoding and default phase durations for tlc_one_way
package tlc_pkg;

  typedef enum logic [1:0] {
    S_RED     = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam int DEF_RED_CYCLES    = 5;
  localparam int DEF_GREEN_CYCLES  = 4;
  localparam int DEF_YELLOW_CYCLES = 2;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - loadable up-counter with terminal-count flag for phase timing
module tlc_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // load restarts the phase at zero; tc marks the last cycle of the phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/tlc_one_way.sv
// rtl/tlc_one_way.sv - one-way traffic light RED->GREEN->YELLOW Moore FSM
// Optional status outputs (state_o, phase_done) under macro TLC_STATUS_EN.
module tlc_one_way
  import tlc_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       clear,
  output logic       RED_out,
  output logic       YELLOW_out,
  output logic       GREEN_out
`ifdef TLC_STATUS_EN
  ,
  output logic [1:0] state_o,
  output logic       phase_done
`endif
);

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;
  logic             tc;
  logic             advance;

  function automatic logic [CNT_W-1:0] last_of(input state_t s);
    case (s)
      S_RED:    return RED_LAST;
      S_GREEN:  return GREEN_LAST;
      S_YELLOW: return YELLOW_LAST;
      default:  return '0;
    endcase
  endfunction

  assign limit = last_of(state);

  tlc_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (clear),
    .load  (advance),
    .limit (limit),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= S_RED;
    end else begin
      state <= state_next;
    end
  end

  // the illegal encoding shows RED and is forced back to a fresh RED phase
  always_comb begin
    state_next = state;
    advance    = tc;
    RED_out    = 1'b0;
    YELLOW_out = 1'b0;
    GREEN_out  = 1'b0;
    case (state)
      S_RED: begin
        RED_out = 1'b1;
        if (tc) state_next = S_GREEN;
      end
      S_GREEN: begin
        GREEN_out = 1'b1;
        if (tc) state_next = S_YELLOW;
      end
      S_YELLOW: begin
        YELLOW_out = 1'b1;
        if (tc) state_next = S_RED;
      end
      default: begin
        RED_out    = 1'b1;
        state_next = S_RED;
        advance    = 1'b1;
      end
    endcase
  end

`ifdef TLC_STATUS_EN
  logic [CNT_W-1:0] count_next;

  assign count_next = advance ? '0 : count + CNT_W'(1);
  assign state_o    = state;

  // registered from next-cycle values so the pulse stays a pure state decode
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      phase_done <= 1'b0;
    end else begin
      phase_done <= (count_next == last_of(state_next));
    end
  end
`endif

endmodule

// File: tb/tb_tlc_one_way.sv
// tb/tb_tlc_one_way.sv - self-checking bench for tlc_one_way (status checks under TLC_STATUS_EN)
module tb_tlc_one_way;

  logic clk;
  logic clear;
  logic clear_s;
  logic red, yel, grn;
  logic red_s, yel_s, grn_s;
`ifdef TLC_STATUS_EN
  logic [1:0] state_o, state_o_s;
  logic       phase_done, phase_done_s;
`endif

  int checks   = 0;
  int failures = 0;

  tlc_one_way dut (
    .clk        (clk),
    .clear      (clear),
    .RED_out    (red),
    .YELLOW_out (yel),
    .GREEN_out  (grn)
`ifdef TLC_STATUS_EN
    ,
    .state_o    (state_o),
    .phase_done (phase_done)
`endif
  );

  tlc_one_way #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .CNT_W         (4)
  ) dut_s (
    .clk        (clk),
    .clear      (clear_s),
    .RED_out    (red_s),
    .YELLOW_out (yel_s),
    .GREEN_out  (grn_s)
`ifdef TLC_STATUS_EN
    ,
    .state_o    (state_o_s),
    .phase_done (phase_done_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [2:0] ryg;
    logic       pd;
  } vec_t;

  // lamp code: 0 RED, 1 GREEN, 2 YELLOW; bits are {red, yellow, green}
  function automatic logic [2:0] ryg_of(input int code);
    case (code)
      0:       return 3'b100;
      1:       return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int lamp_at(input int t, input int r, input int g, input int y);
    int p;
    p = t % (r + g + y);
    if (p < r) return 0;
    if (p < r + g) return 1;
    return 2;
  endfunction

  function automatic logic done_at(input int t, input int r, input int g, input int y);
    int p;
    p = t % (r + g + y);
    return (p == r - 1) || (p == r + g - 1) || (p == r + g + y - 1);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_lamps(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s lamps ryg got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic check_onehot(input string name, input logic [2:0] got);
    checks++;
    if ($countones(got) != 1) begin
      failures++;
      $display("FAIL %s onehot ryg got=%b exp=one lamp", name, got);
    end
  endtask

  vec_t  tbl[23];
  string lamp_pat = "RRRRGGGGYYRRRRRGGGGY";
  string done_pat = "00010001010000100010";
  int    t;
  int    ts;

  initial begin
    clear   = 1'b0;
    clear_s = 1'b0;

    for (int i = 0; i < 3; i++) tbl[i] = '{clr: 1'b0, ryg: 3'b100, pd: 1'b0};
    for (int i = 0; i < 20; i++) begin
      tbl[i+3].clr = 1'b1;
      tbl[i+3].ryg = (lamp_pat[i] == "R") ? 3'b100 : (lamp_pat[i] == "G") ? 3'b001 : 3'b010;
      tbl[i+3].pd  = (done_pat[i] == "1");
    end

    // reset hold then 20 edges after release
    for (int i = 0; i < 23; i++) begin
      clear = tbl[i].clr;
      if (i > 0) @(posedge clk);
      #1;
      check_lamps($sformatf("table[%0d]", i), {red, yel, grn}, tbl[i].ryg);
`ifdef TLC_STATUS_EN
      check($sformatf("table_pd[%0d]", i), int'(phase_done), int'(tbl[i].pd));
      check($sformatf("table_st[%0d]", i), int'(state_o),
            (tbl[i].ryg == 3'b100) ? 0 : (tbl[i].ryg == 3'b001) ? 1 : 2);
`endif
    end

    // advance to mid-GREEN, then assert clear between edges
    t = 20;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1; t++;
    end
    check_lamps("pre_async_green", {red, yel, grn}, ryg_of(lamp_at(t, 5, 4, 2)));
    check("pre_async_is_green", lamp_at(t, 5, 4, 2), 1);
    #2 clear = 1'b0;
    #1;
    check_lamps("async_clear_red", {red, yel, grn}, 3'b100);
`ifdef TLC_STATUS_EN
    check("async_clear_state", int'(state_o), 0);
    check("async_clear_pd", int'(phase_done), 0);
`endif
    #1 clear = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check_lamps($sformatf("post_async_edge%0d", k), {red, yel, grn}, (k < 5) ? 3'b100 : 3'b001);
    end

    // fastest parameters: one cycle per light
    check_lamps("small_reset", {red_s, yel_s, grn_s}, 3'b100);
    #2 clear_s = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check_lamps($sformatf("small_edge%0d", k), {red_s, yel_s, grn_s}, ryg_of(k % 3));
    end

    // randomized clear activity against the arithmetic model
    clear   = 1'b0;
    clear_s = 1'b0;
    t  = 0;
    ts = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 220; c++) begin
      #2;
      if (clear) clear = ($urandom_range(19, 0) != 0);
      else       clear = ($urandom_range(2, 0) == 0);
      clear_s = clear;
      #1;
      if (!clear) begin
        t  = 0;
        ts = 0;
        check_lamps($sformatf("rnd_async[%0d]", c), {red, yel, grn}, 3'b100);
      end
      @(posedge clk);
      if (clear) begin
        t++;
        ts++;
      end
      #1;
      check_lamps($sformatf("rnd[%0d]", c), {red, yel, grn}, ryg_of(lamp_at(t, 5, 4, 2)));
      check_lamps($sformatf("rnd_s[%0d]", c), {red_s, yel_s, grn_s}, ryg_of(lamp_at(ts, 1, 1, 1)));
      check_onehot($sformatf("rnd_oh[%0d]", c), {red, yel, grn});
`ifdef TLC_STATUS_EN
      check($sformatf("rnd_st[%0d]", c), int'(state_o), lamp_at(t, 5, 4, 2));
      check($sformatf("rnd_pd[%0d]", c), int'(phase_done), clear ? int'(done_at(t, 5, 4, 2)) : 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
